// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the Data_Memory port between the CPU MEM stage and the debug unit, with access checks.
// Define DMEM_ARB_STARVE_EN to add the DBG starvation counter and the forced-grant state.
module dmem_arbiter #(
    parameter int WORD_LEN      = 32,
    parameter int DATA_MEM_SIZE = 1024,
    parameter int STARVE_LIMIT  = 8
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_cpu_req,
    input  logic                i_cpu_we,
    input  logic [1:0]          i_cpu_size,
    input  logic                i_cpu_unsigned,
    input  logic [WORD_LEN-1:0] i_cpu_addr,
    input  logic [WORD_LEN-1:0] i_cpu_wdata,
    input  logic                i_dbg_req,
    input  logic                i_dbg_we,
    input  logic [1:0]          i_dbg_size,
    input  logic                i_dbg_unsigned,
    input  logic [WORD_LEN-1:0] i_dbg_addr,
    input  logic [WORD_LEN-1:0] i_dbg_wdata,
    input  logic                i_dbg_lock,
    output logic                o_cpu_gnt,
    output logic                o_dbg_gnt,
    output logic                o_cpu_rvalid,
    output logic                o_dbg_rvalid,
    output logic [WORD_LEN-1:0] o_cpu_rdata,
    output logic [WORD_LEN-1:0] o_dbg_rdata,
    output logic                o_cpu_err,
    output logic                o_dbg_err,
    output logic                o_cpu_stall,
    output logic                o_mem_we,
    output logic [1:0]          o_mem_size,
    output logic                o_mem_unsigned,
    output logic [WORD_LEN-1:0] o_mem_addr,
    output logic [WORD_LEN-1:0] o_mem_wdata,
    input  logic [WORD_LEN-1:0] i_mem_rdata
);
    typedef enum logic [1:0] {
        IDLE,
`ifdef DMEM_ARB_STARVE_EN
        FORCE,
`endif
        LOCK
    } state_t;

    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_limit
        $error("STARVE_LIMIT must be in 1..15");
    end

    state_t              state_q, state_d;
    logic                cpu_gnt, dbg_gnt, gnt, sel_we, sel_uns, bad;
    logic [1:0]          sel_size;
    logic [2:0]          nbytes;
    logic [WORD_LEN-1:0] sel_addr, sel_wdata;
    logic [WORD_LEN:0]   end_addr;
    logic [1:0]          mem_size_q, mem_size_d;
    logic                mem_uns_q, mem_uns_d;
    logic [WORD_LEN-1:0] mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
    logic                cpu_rvalid_q, cpu_rvalid_d, dbg_rvalid_q, dbg_rvalid_d;
    logic                cpu_err_q, cpu_err_d, dbg_err_q, dbg_err_d;
    logic [WORD_LEN-1:0] cpu_rdata_q, cpu_rdata_d, dbg_rdata_q, dbg_rdata_d;
`ifdef DMEM_ARB_STARVE_EN
    localparam logic [3:0] LIM = 4'(STARVE_LIMIT);
    logic [3:0]          cnt_q, cnt_d;
`endif

    always_comb begin
        cpu_gnt = 1'b0;
        dbg_gnt = 1'b0;
        state_d = state_q;
        case (state_q)
            IDLE: begin
                cpu_gnt = i_cpu_req;
                dbg_gnt = i_dbg_req && !i_cpu_req;
                if (dbg_gnt && i_dbg_lock) state_d = LOCK;
`ifdef DMEM_ARB_STARVE_EN
                // this denial is the one that brings the counter up to the limit
                if (i_cpu_req && i_dbg_req && cnt_q >= LIM - 4'd1) state_d = FORCE;
`endif
            end
`ifdef DMEM_ARB_STARVE_EN
            FORCE: begin
                dbg_gnt = i_dbg_req;
                state_d = i_dbg_lock ? LOCK : IDLE;
            end
`endif
            default: begin
                dbg_gnt = i_dbg_req;
                if (!i_dbg_lock) state_d = IDLE;
            end
        endcase
`ifdef DMEM_ARB_STARVE_EN
        cnt_d = (!i_dbg_req || dbg_gnt) ? 4'd0 : (cnt_q >= LIM) ? LIM : cnt_q + 4'd1;
`endif
    end

    always_comb begin
        gnt       = cpu_gnt || dbg_gnt;
        sel_we    = dbg_gnt ? i_dbg_we : i_cpu_we;
        sel_size  = dbg_gnt ? i_dbg_size : i_cpu_size;
        sel_uns   = dbg_gnt ? i_dbg_unsigned : i_cpu_unsigned;
        sel_addr  = dbg_gnt ? i_dbg_addr : i_cpu_addr;
        sel_wdata = dbg_gnt ? i_dbg_wdata : i_cpu_wdata;
        nbytes    = 3'd1 << sel_size;
        end_addr  = {1'b0, sel_addr} + (WORD_LEN+1)'(nbytes);
        bad       = sel_size == 2'b11 || (sel_size == 2'b01 && sel_addr[0]) ||
                    (sel_size == 2'b10 && sel_addr[1:0] != 2'b00) ||
                    end_addr > (WORD_LEN+1)'(DATA_MEM_SIZE);
        mem_size_d   = gnt ? sel_size : mem_size_q;
        mem_uns_d    = gnt ? sel_uns : mem_uns_q;
        mem_addr_d   = gnt ? sel_addr : mem_addr_q;
        mem_wdata_d  = gnt ? sel_wdata : mem_wdata_q;
        cpu_rvalid_d = cpu_gnt && !sel_we && !bad;
        dbg_rvalid_d = dbg_gnt && !sel_we && !bad;
        cpu_err_d    = cpu_gnt && bad;
        dbg_err_d    = dbg_gnt && bad;
        cpu_rdata_d  = cpu_rvalid_d ? i_mem_rdata : cpu_rdata_q;
        dbg_rdata_d  = dbg_rvalid_d ? i_mem_rdata : dbg_rdata_q;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= IDLE;
            mem_size_q   <= 2'b10;
            mem_uns_q    <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            cpu_rvalid_q <= 1'b0;
            dbg_rvalid_q <= 1'b0;
            cpu_err_q    <= 1'b0;
            dbg_err_q    <= 1'b0;
            cpu_rdata_q  <= '0;
            dbg_rdata_q  <= '0;
`ifdef DMEM_ARB_STARVE_EN
            cnt_q        <= 4'd0;
`endif
        end else begin
            state_q      <= state_d;
            mem_size_q   <= mem_size_d;
            mem_uns_q    <= mem_uns_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            cpu_rvalid_q <= cpu_rvalid_d;
            dbg_rvalid_q <= dbg_rvalid_d;
            cpu_err_q    <= cpu_err_d;
            dbg_err_q    <= dbg_err_d;
            cpu_rdata_q  <= cpu_rdata_d;
            dbg_rdata_q  <= dbg_rdata_d;
`ifdef DMEM_ARB_STARVE_EN
            cnt_q        <= cnt_d;
`endif
        end
    end

    assign o_cpu_gnt      = cpu_gnt;
    assign o_dbg_gnt      = dbg_gnt;
    assign o_cpu_stall    = i_cpu_req && !cpu_gnt;
    assign o_cpu_rvalid   = cpu_rvalid_q;
    assign o_dbg_rvalid   = dbg_rvalid_q;
    assign o_cpu_err      = cpu_err_q;
    assign o_dbg_err      = dbg_err_q;
    assign o_cpu_rdata    = cpu_rdata_q;
    assign o_dbg_rdata    = dbg_rdata_q;
    assign o_mem_we       = gnt && sel_we && !bad;
    assign o_mem_size     = mem_size_d;
    assign o_mem_unsigned = mem_uns_d;
    assign o_mem_addr     = mem_addr_d;
    assign o_mem_wdata    = mem_wdata_d;
endmodule
